// File: rtl/aftab_gpio_pkg.sv
// aftab_gpio_pkg
//   Shared definitions for the AFTAB GPIO bank: register map offsets,
//   register index values (offset / 4), the bus FSM state type and the
//   ready-latency counter width.
//   No ports.
package aftab_gpio_pkg;

   localparam int CNT_W = 4;

   localparam logic [31:0] OFF_IN   = 32'h00;
   localparam logic [31:0] OFF_OUT  = 32'h04;
   localparam logic [31:0] OFF_IE   = 32'h08;
   localparam logic [31:0] OFF_MODE = 32'h0C;
   localparam logic [31:0] OFF_IP   = 32'h10;
   localparam logic [31:0] MAP_SIZE = 32'h14;

   // Register index as carried from the bus FSM to the register file.
   localparam logic [2:0] IDX_IN   = OFF_IN[4:2];
   localparam logic [2:0] IDX_OUT  = OFF_OUT[4:2];
   localparam logic [2:0] IDX_IE   = OFF_IE[4:2];
   localparam logic [2:0] IDX_MODE = OFF_MODE[4:2];
   localparam logic [2:0] IDX_IP   = OFF_IP[4:2];

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2,
      DONE = 2'd3
   } gpio_state_e;

endpackage

// File: rtl/aftab_gpio_bus_fsm.sv
// aftab_gpio_bus_fsm
//   Address decode, ready-latency counter and bus handshake FSM.
//   Handshake: readmem/writemem are held by the core until memDataReady.
//   A selected request seen in IDLE is captured (direction, register index,
//   lane); after READY_LATENCY edges the FSM sits one cycle in ACK, which is
//   the single cycle where commit=1 (memDataReady). DONE then waits for both
//   requests to drop so a held request is never serviced twice. Dropping the
//   request while in WAIT aborts the access with no commit.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   readmem, writemem core requests (write wins if both high)
//   addressBus        byte address
//   commit            one-cycle strobe in the ACK cycle
//   is_write          captured direction of the current access
//   reg_idx, lane     captured register index and byte lane
//   state             current FSM state (debug)
module aftab_gpio_bus_fsm
   import aftab_gpio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR     = 32'h0000_2000,
   parameter int          READY_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        readmem,
   input  logic        writemem,
   input  logic [31:0] addressBus,
   output logic        commit,
   output logic        is_write,
   output logic [2:0]  reg_idx,
   output logic [1:0]  lane,
   output gpio_state_e state
);

   gpio_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic [2:0]       idx_q, idx_d;
   logic [1:0]       lane_q, lane_d;

   logic [31:0] offset;
   logic        sel;
   logic        req;
   logic        unused_offset_bits;

   assign offset = addressBus - BASE_ADDR;
   assign sel    = (addressBus >= BASE_ADDR) && (offset < MAP_SIZE);
   assign req    = readmem || writemem;
   assign unused_offset_bits = ^offset[31:5];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      lane_d  = lane_q;
      case (state_q)
         IDLE: begin
            if (sel && req) begin
               state_d = WAIT;
               cnt_d   = CNT_W'(READY_LATENCY - 1);
               wr_d    = writemem;
               idx_d   = offset[4:2];
               lane_d  = offset[1:0];
            end
         end
         WAIT: begin
            if (!req) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ACK: begin
            state_d = DONE;
         end
         DONE: begin
            if (!req) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         lane_q  <= lane_d;
      end
   end

   assign commit   = (state_q == ACK);
   assign is_write = wr_q;
   assign reg_idx  = idx_q;
   assign lane     = lane_q;
   assign state    = state_q;

endmodule

// File: rtl/aftab_gpio_bank.sv
// aftab_gpio_bank
//   Memory-mapped GPIO bank: IN (captured on load_gpio), OUT, IE, MODE
//   (1=rising edge, 0=level) and IP (write-1-to-clear) registers, byte-wide
//   little-endian access, registered interrupt |(IP & IE).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   readmem, writemem        core requests, held until memDataReady
//   addressBus, dataBusIn    byte address and write byte
//   dataBusOut, memDataReady read byte (only in the ready cycle) and pulse
//   load_gpio, in_gpio       capture strobe and input pins
//   out_gpio                 OUT register
//   gpio_interrupt           registered interrupt request
//   dbg_state                bus FSM state (debug)
module aftab_gpio_bank
   import aftab_gpio_pkg::*;
#(
   parameter int               WIDTH         = 32,
   parameter logic [31:0]      BASE_ADDR     = 32'h0000_2000,
   parameter int               READY_LATENCY = 1,
   parameter logic [WIDTH-1:0] OUT_RESET     = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             readmem,
   input  logic             writemem,
   input  logic [31:0]      addressBus,
   input  logic [7:0]       dataBusIn,
   output logic [7:0]       dataBusOut,
   output logic             memDataReady,
   input  logic             load_gpio,
   input  logic [WIDTH-1:0] in_gpio,
   output logic [WIDTH-1:0] out_gpio,
   output logic             gpio_interrupt,
   output gpio_state_e      dbg_state
);

   localparam int NB = WIDTH / 8;

   logic       commit, is_write;
   logic [2:0] reg_idx;
   logic [1:0] lane;

   aftab_gpio_bus_fsm #(
      .BASE_ADDR     (BASE_ADDR),
      .READY_LATENCY (READY_LATENCY)
   ) u_bus_fsm (
      .clk        (clk),
      .rst        (rst),
      .readmem    (readmem),
      .writemem   (writemem),
      .addressBus (addressBus),
      .commit     (commit),
      .is_write   (is_write),
      .reg_idx    (reg_idx),
      .lane       (lane),
      .state      (dbg_state)
   );

   logic [WIDTH-1:0] in_q, in_d, in_prev_q, in_prev_d;
   logic [WIDTH-1:0] out_q, out_d, ie_q, ie_d, mode_q, mode_d, ip_q, ip_d;
   logic             irq_q, irq_d;

   logic [WIDTH-1:0] wr_mask, wr_data, w1c, hw_set;
   logic [31:0]      rd_word;
   logic             wr_en;

   // Read path uses current register values, so an IP read returns the
   // value before any update that happens in the same cycle.
   always_comb begin
      rd_word = '0;
      case (reg_idx)
         IDX_IN:   rd_word[WIDTH-1:0] = in_q;
         IDX_OUT:  rd_word[WIDTH-1:0] = out_q;
         IDX_IE:   rd_word[WIDTH-1:0] = ie_q;
         IDX_MODE: rd_word[WIDTH-1:0] = mode_q;
         IDX_IP:   rd_word[WIDTH-1:0] = ip_q;
         default:  rd_word = '0;
      endcase
   end

   assign dataBusOut   = (commit && !is_write) ? rd_word[{lane, 3'b000} +: 8] : 8'h00;
   assign memDataReady = commit;

   // Lanes at or above NB never get mask bits, so those writes drop out.
   always_comb begin
      wr_mask = '0;
      wr_data = '0;
      for (int b = 0; b < NB; b++) begin
         if (lane == 2'(b)) begin
            wr_mask[b*8 +: 8] = 8'hFF;
            wr_data[b*8 +: 8] = dataBusIn;
         end
      end
   end

   assign wr_en = commit && is_write;

   always_comb begin
      in_d      = load_gpio ? in_gpio : in_q;
      in_prev_d = in_q;
      out_d     = out_q;
      ie_d      = ie_q;
      mode_d    = mode_q;
      w1c       = '0;
      if (wr_en) begin
         case (reg_idx)
            IDX_OUT:  out_d  = (out_q  & ~wr_mask) | wr_data;
            IDX_IE:   ie_d   = (ie_q   & ~wr_mask) | wr_data;
            IDX_MODE: mode_d = (mode_q & ~wr_mask) | wr_data;
            IDX_IP:   w1c    = wr_data;
            default:  ;
         endcase
      end
      // Hardware set is OR-ed after the clear so a same-cycle set wins,
      // and a level input that stays high re-sets the bit every cycle.
      hw_set = (mode_q & in_q & ~in_prev_q) | (~mode_q & in_q);
      ip_d   = (ip_q & ~w1c) | hw_set;
      irq_d  = |(ip_q & ie_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_q      <= '0;
         in_prev_q <= '0;
         out_q     <= OUT_RESET;
         ie_q      <= '0;
         mode_q    <= '0;
         ip_q      <= '0;
         irq_q     <= 1'b0;
      end else begin
         in_q      <= in_d;
         in_prev_q <= in_prev_d;
         out_q     <= out_d;
         ie_q      <= ie_d;
         mode_q    <= mode_d;
         ip_q      <= ip_d;
         irq_q     <= irq_d;
      end
   end

   assign out_gpio       = out_q;
   assign gpio_interrupt = irq_q;

endmodule

// File: tb/tb_aftab_gpio_bank.sv
// tb_aftab_gpio_bank
//   Directed bench. Instance A: WIDTH=32, base 0x2000, latency 3,
//   OUT reset 0xA5. Instance B: WIDTH=16, base 0x3000, latency 1.
//   Both share the bus and GPIO inputs; each is selected by its address.
module tb_aftab_gpio_bank;
   import aftab_gpio_pkg::*;

   // ---------------- clock / reset / signals ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        readmem, writemem, load_gpio;
   logic [31:0] addressBus, in_gpio;
   logic [7:0]  dataBusIn;

   logic [7:0]  dout_a, dout_b;
   logic        rdy_a, rdy_b, irq_a, irq_b;
   logic [31:0] out_a;
   logic [15:0] out_b;
   gpio_state_e st_a, st_b;

   always #5 clk = ~clk;

   aftab_gpio_bank #(
      .WIDTH(32), .BASE_ADDR(32'h0000_2000), .READY_LATENCY(3), .OUT_RESET(32'h0000_00A5)
   ) dut_a (
      .clk(clk), .rst(rst), .readmem(readmem), .writemem(writemem),
      .addressBus(addressBus), .dataBusIn(dataBusIn), .dataBusOut(dout_a),
      .memDataReady(rdy_a), .load_gpio(load_gpio), .in_gpio(in_gpio),
      .out_gpio(out_a), .gpio_interrupt(irq_a), .dbg_state(st_a)
   );

   aftab_gpio_bank #(
      .WIDTH(16), .BASE_ADDR(32'h0000_3000), .READY_LATENCY(1), .OUT_RESET(16'h0000)
   ) dut_b (
      .clk(clk), .rst(rst), .readmem(readmem), .writemem(writemem),
      .addressBus(addressBus), .dataBusIn(dataBusIn), .dataBusOut(dout_b),
      .memDataReady(rdy_b), .load_gpio(load_gpio), .in_gpio(in_gpio[15:0]),
      .out_gpio(out_b), .gpio_interrupt(irq_b), .dbg_state(st_b)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   logic [7:0] rd;
   bit         got;
   int         lat, ex;

   // One bus access; lat = edges after the sampling edge until ready,
   // ex = ready pulses seen while the request is held afterwards.
   task automatic bus(input bit ib, input bit wr, input logic [31:0] addr,
                      input logic [7:0] wdata, input int hold, input int budget,
                      output logic [7:0] rdata, output bit g, output int l, output int e);
      @(posedge clk); #1;
      addressBus = addr; dataBusIn = wdata; writemem = wr; readmem = !wr;
      @(posedge clk);
      g = 1'b0; l = 0; e = 0; rdata = 8'h00;
      for (int n = 1; n <= budget && !g; n++) begin
         @(negedge clk);
         if (ib ? rdy_b : rdy_a) begin
            g = 1'b1; l = n - 1; rdata = ib ? dout_b : dout_a;
         end
      end
      if (g) begin
         repeat (hold) begin
            @(negedge clk);
            if (ib ? rdy_b : rdy_a) e++;
         end
      end
      @(posedge clk); #1;
      writemem = 1'b0; readmem = 1'b0;
   endtask

   task automatic wr_byte(input bit ib, input logic [31:0] a, input logic [7:0] d, input string tag);
      bus(ib, 1'b1, a, d, 0, 30, rd, got, lat, ex);
      check({tag, " ready"}, 32'(got), 32'd1);
   endtask

   task automatic rd_chk(input bit ib, input logic [31:0] a, input logic [7:0] exp, input string tag);
      bus(ib, 1'b0, a, 8'h00, 0, 30, rd, got, lat, ex);
      check({tag, " ready"}, 32'(got), 32'd1);
      check({tag, " data"}, 32'(rd), 32'(exp));
   endtask

   task automatic load(input logic [31:0] v);
      @(posedge clk); #1;
      in_gpio = v; load_gpio = 1'b1;
      @(posedge clk); #1;
      load_gpio = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int cnt;
      rst = 1'b0; readmem = 1'b0; writemem = 1'b0; load_gpio = 1'b0;
      addressBus = '0; in_gpio = '0; dataBusIn = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset out_a", out_a, 32'h0000_00A5);
      check("reset out_b", 32'(out_b), 32'h0);
      check("reset irq_a", 32'(irq_a), 32'h0);
      check("reset rdy_a", 32'(rdy_a), 32'h0);
      check("reset dout_a", 32'(dout_a), 32'h0);
      check("reset state_a", 32'(st_a), 32'(IDLE));
      @(posedge clk); #1 rst = 1'b1;

      // Latency and reset-value read
      rd_chk(1'b0, 32'h2004, 8'hA5, "rd out_a lane0");
      check("latency a", lat, 3);
      rd_chk(1'b1, 32'h3004, 8'h00, "rd out_b lane0");
      check("latency b", lat, 1);

      // OUT byte writes; first one held through DONE
      bus(1'b0, 1'b1, 32'h2004, 8'h78, 5, 30, rd, got, lat, ex);
      check("held wr ready", 32'(got), 32'd1);
      check("held wr extra ready", ex, 0);
      check("out_a after lane0", out_a, 32'h0000_0078);
      wr_byte(1'b0, 32'h2005, 8'h56, "wr out lane1");
      wr_byte(1'b0, 32'h2006, 8'h34, "wr out lane2");
      wr_byte(1'b0, 32'h2007, 8'h12, "wr out lane3");
      check("out_a word", out_a, 32'h1234_5678);
      check("out_b untouched", 32'(out_b), 32'h0);
      rd_chk(1'b0, 32'h2006, 8'h34, "rd out_a lane2");

      // Request dropped during WAIT: no write, no ready
      @(posedge clk); #1;
      addressBus = 32'h2004; dataBusIn = 8'hEE; writemem = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk); #1 writemem = 1'b0;
      cnt = 0;
      repeat (6) begin @(negedge clk); if (rdy_a) cnt++; end
      check("abort ready count", cnt, 0);
      check("abort out_a", out_a, 32'h1234_5678);
      check("abort state", 32'(st_a), 32'(IDLE));

      // Rising-edge interrupt on bit 0
      wr_byte(1'b0, 32'h2008, 8'h01, "wr ie");
      wr_byte(1'b0, 32'h200C, 8'h01, "wr mode");
      load(32'h1);
      @(negedge clk); check("edge irq N", 32'(irq_a), 32'h0);
      @(negedge clk); check("edge irq N+1", 32'(irq_a), 32'h0);
      @(negedge clk); check("edge irq N+2", 32'(irq_a), 32'h1);
      check("irq_b masked", 32'(irq_b), 32'h0);
      rd_chk(1'b0, 32'h2010, 8'h01, "rd ip edge");
      wr_byte(1'b0, 32'h2010, 8'h01, "w1c ip0");
      @(negedge clk); check("irq after w1c commit", 32'(irq_a), 32'h1);
      @(negedge clk); check("irq falls", 32'(irq_a), 32'h0);
      load(32'h1);
      repeat (3) @(negedge clk);
      check("reload no irq", 32'(irq_a), 32'h0);
      rd_chk(1'b0, 32'h2010, 8'h00, "rd ip reload");

      // Level interrupt on bit 3, IE enabled after IP is pending
      load(32'h8);
      repeat (3) @(negedge clk);
      check("level masked irq", 32'(irq_a), 32'h0);
      wr_byte(1'b0, 32'h2008, 8'h08, "wr ie bit3");
      @(negedge clk); check("ie commit irq old", 32'(irq_a), 32'h0);
      @(negedge clk); check("ie commit irq new", 32'(irq_a), 32'h1);
      wr_byte(1'b0, 32'h2010, 8'h08, "w1c level high");
      rd_chk(1'b0, 32'h2010, 8'h08, "rd ip level stuck");
      check("level irq held", 32'(irq_a), 32'h1);
      load(32'h0);
      wr_byte(1'b0, 32'h2010, 8'h08, "w1c level low");
      rd_chk(1'b0, 32'h2010, 8'h00, "rd ip level cleared");
      repeat (2) @(negedge clk);
      check("level irq low", 32'(irq_a), 32'h0);

      // WIDTH=16 instance lanes and unselected addresses
      load(32'hFFFF_FFFF);
      rd_chk(1'b1, 32'h3001, 8'hFF, "b rd in lane1");
      rd_chk(1'b1, 32'h3002, 8'h00, "b rd in lane2");
      wr_byte(1'b1, 32'h3000, 8'h00, "b wr in");
      rd_chk(1'b1, 32'h3000, 8'hFF, "b rd in lane0 ro");
      wr_byte(1'b1, 32'h3007, 8'h55, "b wr out lane3");
      check("b out lane3 ignored", 32'(out_b), 32'h0);
      rd_chk(1'b1, 32'h3007, 8'h00, "b rd out lane3");
      wr_byte(1'b1, 32'h3005, 8'h9C, "b wr out lane1");
      check("b out lane1", 32'(out_b), 32'h9C00);
      bus(1'b1, 1'b0, 32'h3014, 8'h00, 0, 20, rd, got, lat, ex);
      check("b unselected no ready", 32'(got), 32'd0);
      bus(1'b0, 1'b1, 32'h2014, 8'hFF, 0, 20, rd, got, lat, ex);
      check("a unselected no ready", 32'(got), 32'd0);
      check("a unselected out", out_a, 32'h1234_5678);

      // Reset asserted during WAIT of an OUT write
      @(posedge clk); #1;
      addressBus = 32'h2004; dataBusIn = 8'hFF; writemem = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("pre-reset state", 32'(st_a), 32'(WAIT));
      rst = 1'b0;
      #1;
      check("reset state async", 32'(st_a), 32'(IDLE));
      writemem = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      repeat (4) @(negedge clk);
      check("reset no commit out_a", out_a, 32'h0000_00A5);
      check("post-reset state", 32'(st_a), 32'(IDLE));
      wr_byte(1'b0, 32'h2004, 8'h3C, "post-reset wr");
      check("post-reset out_a", out_a, 32'h0000_003C);
      rd_chk(1'b0, 32'h2004, 8'h3C, "post-reset rd");
      check("post-reset latency", lat, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
